// File: rtl/morph_multiscale_stream.sv
// morph_multiscale_stream: streaming multiscale morphological gradient
// (3x3 and 5x5 max-min) over a raster-order pixel stream.
// Latency: one cycle from accepted pixel to valid_out. Backpressure: none;
// every cycle with valid_in=1 is consumed.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   valid_in, sof_in  input qualifier and start-of-frame marker
//   pixel_in          input pixel (DATA_W)
//   mode              result select, latched at the first pixel of a frame
//   thresh            binarisation threshold (only with MORPH_THRESH_EN)
//   valid_out,eof_out output qualifier, last-pixel-of-frame marker
//   pixel_out         result pixel, held while valid_out=0
//
// Optional feature: define MORPH_THRESH_EN to add the thresh input and
// binarise the output (all-ones when result > thresh, else zero).
module morph_multiscale_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic [1:0]        mode,
`ifdef MORPH_THRESH_EN
  input  logic [DATA_W-1:0] thresh,
`endif
  output logic              valid_out,
  output logic              eof_out,
  output logic [DATA_W-1:0] pixel_out
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  // A full 5x5 window exists only from the fifth row/column onward.
  localparam logic [CW-1:0] COL_MIN  = CW'(4);
  localparam logic [RW-1:0] ROW_MIN  = RW'(4);

  localparam logic [1:0] MODE_G3  = 2'd0;
  localparam logic [1:0] MODE_G5  = 2'd1;
  localparam logic [1:0] MODE_AVG = 2'd2;

  // ------------------------------------------------------------------
  // Position tracking
  // ------------------------------------------------------------------
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [1:0]    mode_q;

  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          at_origin;
  logic          at_last;
  logic          accept;
  logic [1:0]    frame_mode;

  // sof_in overrides the running counters for the pixel it qualifies.
  assign cur_col   = sof_in ? '0 : col_q;
  assign cur_row   = sof_in ? '0 : row_q;
  assign at_origin = (cur_col == '0) && (cur_row == '0);
  assign at_last   = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
  // Nothing advances in the reset cycle even if valid_in is high.
  assign accept    = valid_in & ~rst;
  // The origin pixel already belongs to the new frame, so it sees the new
  // mode rather than the previous frame's latched value.
  assign frame_mode = at_origin ? mode : mode_q;

  // ------------------------------------------------------------------
  // Line buffers and window storage (no reset: the border mask keeps
  // stale or uninitialised contents away from pixel_out)
  // ------------------------------------------------------------------
  // line_buf[k][c] holds the pixel of row r-1-k at column c.
  logic [DATA_W-1:0] line_buf [4][IMG_W];
  // win_q[j][i]: column c-4+j, row r-4+i, for the four previous columns.
  logic [DATA_W-1:0] win_q    [4][5];
  // Column arriving with the current pixel, rows r-4..r.
  logic [DATA_W-1:0] col_now  [5];
  // Full 5x5 window for the current acceptance.
  logic [DATA_W-1:0] win      [5][5];

  always_comb begin
    col_now[0] = line_buf[3][cur_col];
    col_now[1] = line_buf[2][cur_col];
    col_now[2] = line_buf[1][cur_col];
    col_now[3] = line_buf[0][cur_col];
    col_now[4] = pixel_in;
  end

  always_comb begin
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 5; i++) begin
        win[j][i] = (j < 4) ? win_q[j][i] : col_now[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      // Each column shifts one row deeper into the line buffer.
      line_buf[0][cur_col] <= pixel_in;
      line_buf[1][cur_col] <= line_buf[0][cur_col];
      line_buf[2][cur_col] <= line_buf[1][cur_col];
      line_buf[3][cur_col] <= line_buf[2][cur_col];
      for (int i = 0; i < 5; i++) begin
        win_q[0][i] <= win_q[1][i];
        win_q[1][i] <= win_q[2][i];
        win_q[2][i] <= win_q[3][i];
        win_q[3][i] <= col_now[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Max/min over both window sizes
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] d5, e5, d3, e3;

  always_comb begin
    d5 = win[0][0];
    e5 = win[0][0];
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 5; i++) begin
        if (win[j][i] > d5) d5 = win[j][i];
        if (win[j][i] < e5) e5 = win[j][i];
      end
    end
  end

  // Inner 3x3 is rows r-3..r-1, cols c-3..c-1: same centre as the 5x5.
  always_comb begin
    d3 = win[1][1];
    e3 = win[1][1];
    for (int j = 1; j < 4; j++) begin
      for (int i = 1; i < 4; i++) begin
        if (win[j][i] > d3) d3 = win[j][i];
        if (win[j][i] < e3) e3 = win[j][i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Gradient selection and border masking
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] g3, g5;
  logic [DATA_W:0]   g_sum;
  logic [DATA_W-1:0] sel;
  logic              border;
  logic [DATA_W-1:0] result;

  // Max is never below min, so these subtractions cannot wrap.
  assign g3     = d3 - e3;
  assign g5     = d5 - e5;
  assign g_sum  = {1'b0, g3} + {1'b0, g5};
  assign border = (cur_row < ROW_MIN) || (cur_col < COL_MIN);

  always_comb begin
    case (frame_mode)
      MODE_G3:  sel = g3;
      MODE_G5:  sel = g5;
      MODE_AVG: sel = g_sum[DATA_W:1];
      default:  sel = (g3 > g5) ? g3 : g5;
    endcase
  end

`ifdef MORPH_THRESH_EN
  always_comb begin
    if (border) begin
      result = '0;
    end else if (sel > thresh) begin
      result = '1;
    end else begin
      result = '0;
    end
  end
`else
  assign result = border ? '0 : sel;
`endif

  // ------------------------------------------------------------------
  // Counters, mode latch and registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      eof_out   <= 1'b0;
      pixel_out <= '0;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= '0;
    end else begin
      valid_out <= valid_in;
      eof_out   <= valid_in & at_last;
      if (valid_in) begin
        pixel_out <= result;
        if (at_origin) begin
          mode_q <= mode;
        end
        if (cur_col == COL_LAST) begin
          col_q <= '0;
          row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end else begin
          col_q <= cur_col + CW'(1);
          row_q <= cur_row;
        end
      end
    end
  end

endmodule

// File: tb/tb_morph_multiscale_stream.sv
module tb_morph_multiscale_stream;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic       sof_in;
  logic [7:0] pixel_in;
  logic [1:0] mode;
  logic [7:0] thresh;
  logic       valid_out;
  logic       eof_out;
  logic [7:0] pixel_out;

  always #5 clk = ~clk;

  morph_multiscale_stream #(.DATA_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sof_in    (sof_in),
    .pixel_in  (pixel_in),
    .mode      (mode),
`ifdef MORPH_THRESH_EN
    .thresh    (thresh),
`endif
    .valid_out (valid_out),
    .eof_out   (eof_out),
    .pixel_out (pixel_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the frame as an image, addressed by position.
  int img [H][W];
  int mr, mc, mmode, last_pix;
  int vcount, eof_count, eof_at;
  int got [W*H];

  typedef struct {
    int kind;   // 0 constant frame, 1 impulse at (4,4)
    int val;
    int md;
    int r;      // acceptance position to inspect
    int c;
    int exp;    // grey-level result
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int grey(input int r, input int c, input int md);
    int d5, e5, d3, e3, g3, g5;
    if (r < 4 || c < 4) return 0;
    d5 = 0; e5 = 255; d3 = 0; e3 = 255;
    for (int y = r - 4; y <= r; y++) begin
      for (int x = c - 4; x <= c; x++) begin
        if (img[y][x] > d5) d5 = img[y][x];
        if (img[y][x] < e5) e5 = img[y][x];
        if (y >= r - 3 && y <= r - 1 && x >= c - 3 && x <= c - 1) begin
          if (img[y][x] > d3) d3 = img[y][x];
          if (img[y][x] < e3) e3 = img[y][x];
        end
      end
    end
    g3 = d3 - e3;
    g5 = d5 - e5;
    case (md)
      0: return g3;
      1: return g5;
      2: return (g3 + g5) / 2;
      default: return (g3 > g5) ? g3 : g5;
    endcase
  endfunction

  function automatic int finalize(input int g);
`ifdef MORPH_THRESH_EN
    return (g > int'(thresh)) ? 255 : 0;
`else
    return g;
`endif
  endfunction

  // One clock cycle: drive inputs, advance the model, check all outputs.
  task automatic step(input logic r_i, input logic v, input logic s,
                      input int p, input int m);
    int exp_v, exp_e, exp_p, pos, rr, cc;
    rst      = r_i;
    valid_in = v;
    sof_in   = s;
    pixel_in = p[7:0];
    mode     = m[1:0];
    pos      = -1;
    @(posedge clk);
    if (r_i) begin
      exp_v = 0; exp_e = 0; exp_p = 0;
      mr = 0; mc = 0; mmode = 0;
    end else if (v) begin
      rr = s ? 0 : mr;
      cc = s ? 0 : mc;
      img[rr][cc] = p & 255;
      if (rr == 0 && cc == 0) mmode = m & 3;
      exp_p = finalize(grey(rr, cc, mmode));
      exp_v = 1;
      exp_e = (rr == H - 1 && cc == W - 1) ? 1 : 0;
      pos   = rr * W + cc;
      mc = cc + 1;
      mr = rr;
      if (mc == W) begin
        mc = 0;
        mr = (rr + 1) % H;
      end
    end else begin
      exp_v = 0; exp_e = 0; exp_p = last_pix;
    end
    last_pix = exp_p;
    #1;
    chk("valid_out", int'(valid_out), exp_v);
    chk("eof_out", int'(eof_out), exp_e);
    chk("pixel_out", int'(pixel_out), exp_p);
    if (valid_out) begin
      vcount++;
      if (pos >= 0) got[pos] = int'(pixel_out);
    end
    if (eof_out) begin
      eof_count++;
      eof_at = vcount;
    end
  endtask

  task automatic clear_counts();
    vcount = 0; eof_count = 0; eof_at = -1;
  endtask

  task automatic run_frame(input int kind, input int val, input int md);
    int pix;
    clear_counts();
    for (int i = 0; i < W * H; i++) begin
      if (kind == 0) pix = val;
      else if (kind == 1) pix = (i == 4 * W + 4) ? val : 0;
      else pix = int'($urandom_range(255));
      step(1'b0, 1'b1, i == 0, pix, md);
    end
  endtask

  initial begin
    thresh = 8'd100;
    mr = 0; mc = 0; mmode = 0; last_pix = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) img[y][x] = 0;
    clear_counts();

    tbl[0]  = '{0, 100, 2, 7, 7, 0};
    tbl[1]  = '{0, 100, 2, 4, 4, 0};
    tbl[2]  = '{1, 255, 0, 5, 5, 255};
    tbl[3]  = '{1, 255, 0, 7, 7, 255};
    tbl[4]  = '{1, 255, 0, 4, 4, 0};
    tbl[5]  = '{1, 255, 0, 4, 6, 0};
    tbl[6]  = '{1, 255, 0, 6, 3, 0};
    tbl[7]  = '{1, 255, 2, 4, 4, 127};
    tbl[8]  = '{1, 255, 2, 6, 6, 255};
    tbl[9]  = '{1, 255, 2, 4, 7, 127};
    tbl[10] = '{1, 255, 1, 4, 4, 255};
    tbl[11] = '{1, 255, 3, 5, 4, 255};
    tbl[12] = '{1, 255, 0, 2, 2, 0};

    // Reset with valid_in high: the pixel must be ignored.
    step(1'b1, 1'b1, 1'b1, 77, 3);
    step(1'b1, 1'b0, 1'b0, 0, 0);

    // Directed table.
    foreach (tbl[k]) begin
      run_frame(tbl[k].kind, tbl[k].val, tbl[k].md);
      chk($sformatf("table%0d", k), got[tbl[k].r * W + tbl[k].c],
          finalize(tbl[k].exp));
    end

    // Constant frame: 64 outputs, one eof on the last.
    run_frame(0, 100, 2);
    chk("const_vcount", vcount, 64);
    chk("const_eofs", eof_count, 1);
    chk("const_eof_at", eof_at, 64);

`ifdef MORPH_THRESH_EN
    thresh = 8'd200;
    run_frame(1, 255, 2);
    chk("thr200_c22", got[4 * W + 4], 0);
    chk("thr200_c44", got[6 * W + 6], 255);
    thresh = 8'd100;
`endif

    // sof_in at the 20th pixel restarts the frame in mode 1.
    clear_counts();
    for (int i = 0; i < 19; i++)
      step(1'b0, 1'b1, i == 0, int'($urandom_range(255)), 0);
    for (int i = 0; i < W * H; i++)
      step(1'b0, 1'b1, i == 0, int'($urandom_range(255)), 1);
    chk("sof_eofs", eof_count, 1);
    chk("sof_eof_at", eof_at, 19 + 64);

    // Reset mid-frame, then a frame with no sof_in.
    clear_counts();
    for (int i = 0; i < 30; i++)
      step(1'b0, 1'b1, i == 0, int'($urandom_range(255)), 0);
    step(1'b1, 1'b1, 1'b0, 200, 2);
    for (int i = 0; i < W * H; i++)
      step(1'b0, 1'b1, 1'b0, int'($urandom_range(255)), 3);
    chk("rst_eofs", eof_count, 1);
    chk("rst_eof_at", eof_at, 30 + 64);

    // Random frames with gaps, stray sof_in on idle cycles, and mode
    // wiggling away from the first pixel.
    for (int f = 0; f < 6; f++) begin
      int md;
      md = int'($urandom_range(3));
      clear_counts();
      for (int i = 0; i < W * H; i++) begin
        while ($urandom_range(3) == 0)
          step(1'b0, 1'b0, 1'($urandom_range(1)), int'($urandom_range(255)),
               int'($urandom_range(3)));
        step(1'b0, 1'b1, i == 0, int'($urandom_range(255)),
             (i == 0) ? md : int'($urandom_range(3)));
      end
      chk("rand_vcount", vcount, 64);
      chk("rand_eofs", eof_count, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
